sevenseg_scan: RTL and testbench
================================

SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter PRESCALE, default 1000, clocks per digit display slot (>=2).
REQ-003 SHALL have parameter GAP_CYC, default 2, all-digits-off clocks between slots (0 = no gap).
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port value, input, 4*DIGITS, nibble i = value[4i+3:4i] = digit i, digit 0 least significant.
REQ-007 SHALL have port load, input, 1, capture value/hex_mode/lz_suppress into shadow registers.
REQ-008 SHALL have port hex_mode, input, 1, 1 = nibbles 10..15 shown as A,b,C,d,E,F; 0 = BCD.
REQ-009 SHALL have port lz_suppress, input, 1, 1 = blank leading zero digits.
REQ-010 SHALL have port enable, input, 1, 0 = display dark and scan held.
REQ-011 SHALL have port seg_out, output, 7, active-high segments {a,b,c,d,e,f,g} = seg_out[6:0] (a top, b upper-right, c lower-right, d bottom, e lower-left, f upper-left, g middle).
REQ-012 SHALL have port dig_en, output, DIGITS, one-hot active-high digit select.

Function
REQ-013 SHALL register seg_out and dig_en (no combinational path from inputs to outputs).
REQ-014 SHALL update shadow registers on the clk edge where load=1; the change SHALL be visible from the next slot start, never mid-slot.
REQ-015 SHALL decode 0..9 as 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.
REQ-016 SHALL decode 10..15 with hex_mode=1 as 1110111, 0011111, 1001110, 0111101, 1001111, 1000111.
REQ-017 SHALL decode 10..15 with hex_mode=0 as dash 0000001 (error indication).
REQ-018 SHALL, with lz_suppress=1, output seg_out=0000000 for every zero digit above the highest non-zero digit; digit 0 SHALL always be shown (value 0 shows single "0").
REQ-019 SHALL implement FSM states OFF, SHOW, GAP.
REQ-020 OFF: dig_en=0, seg_out=0; enable=1 -> SHOW with digit index 0 and prescaler 0 on next edge.
REQ-021 SHOW: dig_en one-hot at current index, seg_out = decoded shadow nibble; held exactly PRESCALE clocks; then GAP if GAP_CYC>0, else SHOW of next digit.
REQ-022 GAP: dig_en=0, seg_out=0 for exactly GAP_CYC clocks, then SHOW of next digit.
REQ-023 Digit index SHALL advance 0,1,..,DIGITS-1 and wrap to 0; full frame = DIGITS*(PRESCALE+GAP_CYC) clocks.
REQ-024 enable=0 in any state SHALL force OFF on the next edge (outputs dark that edge), resetting index and prescaler.
REQ-025 load coincident with slot boundary SHALL have the new value displayed in the slot that starts on that edge+1 (shadow update wins, decode uses registered shadow).
REQ-026 Prescaler width SHALL be clog2(PRESCALE); no overflow for any legal parameter.

Reset
REQ-027 rst=1 SHALL immediately set state OFF, seg_out=0000000, dig_en=0, index 0, prescaler 0, shadow value 0, shadow hex_mode 0, shadow lz_suppress 0.
REQ-028 Reset deasserted with enable=1 SHALL enter SHOW of digit 0 on the first edge after release.
REQ-029 rst asserted mid-SHOW or mid-GAP SHALL darken outputs asynchronously, without waiting for clk.

Verification (DIGITS=4, PRESCALE=4, GAP_CYC=1)
REQ-030 load value=16'h1234, hex_mode=0, enable=1 -> dig_en sequence 0001,0000,0010,0000,0100,0000,1000,0000 (4/1/4/1.. clocks), seg_out 0110011,1111001,1101101,0110000 for digits 0..3; frame 20 clocks, wraps to 0001.
REQ-031 load 16'h00AF hex_mode=1 lz_suppress=1 -> digit0 1000111, digit1 1110111, digits 2,3 seg_out 0000000 with dig_en still stepping; hex_mode=0 -> digits 0,1 show 0000001.
REQ-032 load 16'h0000 lz_suppress=1 -> digit0 1111110, digits 1..3 blank; lz_suppress=0 -> all four 1111110.
REQ-033 load 16'h5678 during digit1 SHOW clock 2 -> digit1 keeps old pattern through its slot; digit2 shows 1011111 (6).
REQ-034 enable low during GAP -> next edge dig_en=0 seg_out=0; enable high -> SHOW restarts at digit 0 with full 4-clock slot.
REQ-035 rst pulse mid-SHOW between edges -> outputs 0 before next edge; shadow cleared so digit0 shows 1111110 after release.

Source files
------------

// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment scanner: shows one digit per slot with optional blank gaps.
// Shadow registers decouple the display from `value` so that a digit never changes partway through its slot.
module sevenseg_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int GAP_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  lz_suppress,
  input  logic                  enable,
  output logic [6:0]            seg_out,
  output logic [DIGITS-1:0]     dig_en
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {OFF, SHOW, GAP} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [PW-1:0]         pre_q, pre_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [6:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     dig_q, dig_d;
  logic [4*DIGITS-1:0]   val_q, val_d;
  logic                  hex_q, hex_d;
  logic                  lz_q, lz_d;

  logic [IW-1:0]         nxt_idx;
  logic [IW-1:0]         show_idx;
  logic [3:0]            show_nib;
  logic [6:0]            show_seg;
  logic [DIGITS-1:0]     show_dig;
  logic [DIGITS-1:0]     upper_zero;

  function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      4'd10:   s = hex ? 7'b1110111 : 7'b0000001;
      4'd11:   s = hex ? 7'b0011111 : 7'b0000001;
      4'd12:   s = hex ? 7'b1001110 : 7'b0000001;
      4'd13:   s = hex ? 7'b0111101 : 7'b0000001;
      4'd14:   s = hex ? 7'b1001111 : 7'b0000001;
      default: s = hex ? 7'b1000111 : 7'b0000001;
    endcase
    return s;
  endfunction

  // upper_zero[i]: digit i and every digit above it are zero in the shadow value
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_upper_zero
    assign upper_zero[gi] = ~|val_q[4*DIGITS-1:4*gi];
  end

  // Pattern for the slot about to start; uses only registered shadow state
  always_comb begin
    nxt_idx  = (idx_q == IW'(DIGITS-1)) ? '0 : idx_q + IW'(1);
    show_idx = (state_q == SHOW) ? nxt_idx : idx_q;
    show_nib = val_q[{show_idx, 2'b00} +: 4];
    show_dig = DIGITS'(1) << show_idx;
    if (lz_q && (show_idx != '0) && upper_zero[show_idx])
      show_seg = 7'b0000000;
    else
      show_seg = decode(show_nib, hex_q);
  end

  always_comb begin
    val_d = load ? value       : val_q;
    hex_d = load ? hex_mode    : hex_q;
    lz_d  = load ? lz_suppress : lz_q;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    gap_d   = gap_q;
    seg_d   = seg_q;
    dig_d   = dig_q;
    if (!enable) begin
      state_d = OFF;
      idx_d   = '0;
      pre_d   = '0;
      gap_d   = '0;
      seg_d   = '0;
      dig_d   = '0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = SHOW;
          idx_d   = '0;
          pre_d   = '0;
          seg_d   = show_seg;
          dig_d   = show_dig;
        end
        SHOW: begin
          if (pre_q == PW'(PRESCALE-1)) begin
            pre_d = '0;
            idx_d = nxt_idx;
            if (GAP_CYC > 0) begin
              state_d = GAP;
              gap_d   = '0;
              seg_d   = '0;
              dig_d   = '0;
            end else begin
              seg_d = show_seg;
              dig_d = show_dig;
            end
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        GAP: begin
          if (gap_q == GW'(GAP_CYC-1)) begin
            state_d = SHOW;
            pre_d   = '0;
            gap_d   = '0;
            seg_d   = show_seg;
            dig_d   = show_dig;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OFF;
      idx_q   <= '0;
      pre_q   <= '0;
      gap_q   <= '0;
      seg_q   <= '0;
      dig_q   <= '0;
      val_q   <= '0;
      hex_q   <= 1'b0;
      lz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      gap_q   <= gap_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      val_q   <= val_d;
      hex_q   <= hex_d;
      lz_q    <= lz_d;
    end
  end

  assign seg_out = seg_q;
  assign dig_en  = dig_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: a frame-position model (time since scan start, mod frame) checked
// every cycle, plus hand-written frames pinning the segment tables, blanking and timing.
module tb_sevenseg_scan;
  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int GAP_CYC  = 1;
  localparam int SLOT     = PRESCALE + GAP_CYC;
  localparam int FRAME    = DIGITS * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        hex_mode = 1'b0;
  logic        lz_suppress = 1'b0;
  logic        enable = 1'b0;
  logic [6:0]  seg_out;
  logic [3:0]  dig_en;

  int total = 0;
  int bad   = 0;

  sevenseg_scan #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .hex_mode(hex_mode),
    .lz_suppress(lz_suppress), .enable(enable), .seg_out(seg_out), .dig_en(dig_en)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit          m_active = 0;
  int          m_t = 0;
  logic [15:0] m_val = '0;
  bit          m_hex = 0;
  bit          m_lz = 0;
  logic [6:0]  m_snap = '0;
  logic [6:0]  exp_seg = '0;
  logic [3:0]  exp_dig = '0;
  bit          chk_on = 0;

  function automatic logic [6:0] mdec(input logic [15:0] v, input int d, input bit hx, input bit lz);
    logic [6:0] dtab [10];
    logic [6:0] htab [6];
    logic [15:0] up;
    int n;
    dtab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    htab = '{7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    up = v >> (4*d);
    n  = int'(up & 16'h000F);
    if (lz && d > 0 && up == 16'h0) return 7'b0000000;
    if (n < 10) return dtab[n];
    if (hx) return htab[n-10];
    return 7'b0000001;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_active = 0; m_t = 0; m_val = '0; m_hex = 0; m_lz = 0;
    end else begin
      if (!enable) m_active = 0;
      else if (!m_active) begin m_active = 1; m_t = 0; end
      else m_t = (m_t + 1) % FRAME;
      if (m_active && (m_t % SLOT) == 0) m_snap = mdec(m_val, m_t / SLOT, m_hex, m_lz);
      if (load) begin m_val = value; m_hex = hex_mode; m_lz = lz_suppress; end
    end
    if (m_active && (m_t % SLOT) < PRESCALE) begin
      exp_seg = m_snap;
      exp_dig = 4'(1 << (m_t / SLOT));
    end else begin
      exp_seg = '0;
      exp_dig = '0;
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  task automatic model_cmp();
    total++;
    if (seg_out !== exp_seg || dig_en !== exp_dig) begin
      bad++;
      $display("FAIL model t=%0t: got seg=%b dig=%b want seg=%b dig=%b",
               $time, seg_out, dig_en, exp_seg, exp_dig);
    end
  endtask

  always @(negedge clk) if (chk_on) model_cmp();

  // ---------------- directed helpers ----------------
  task automatic lit(input string nm, input logic [6:0] s, input logic [3:0] d);
    total++;
    if (seg_out !== s || dig_en !== d) begin
      bad++;
      $display("FAIL %s t=%0t: got seg=%b dig=%b want seg=%b dig=%b", nm, $time, seg_out, dig_en, s, d);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input logic [15:0] v, input bit hx, input bit lz);
    enable = 1'b0; value = v; hex_mode = hx; lz_suppress = lz; load = 1'b1;
    step();
    load = 1'b0; enable = 1'b1;
    step();
  endtask

  // k = 0 is the first clock of digit 0's slot
  task automatic chk_frame(input string nm, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3, input int ncyc);
    logic [6:0] segs [4];
    segs = '{s0, s1, s2, s3};
    for (int k = 0; k < ncyc; k++) begin
      int slot, w;
      if (k > 0) step();
      @(negedge clk);
      slot = (k % FRAME) / SLOT;
      w    = k % SLOT;
      if (w < PRESCALE) lit(nm, segs[slot], 4'(1 << slot));
      else              lit(nm, 7'b0, 4'b0);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 lit("reset", 7'b0, 4'b0);
    step();
    rst = 1'b0;
    chk_on = 1;
    step();

    start(16'h1234, 0, 0);
    chk_frame("frame_1234", 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, FRAME + 1);

    start(16'h00AF, 1, 1);
    chk_frame("hex_lz", 7'b1000111, 7'b1110111, 7'b0000000, 7'b0000000, FRAME);
    start(16'h00AF, 0, 1);
    chk_frame("bcd_dash", 7'b0000001, 7'b0000001, 7'b0000000, 7'b0000000, FRAME);

    start(16'h0000, 0, 1);
    chk_frame("zero_lz", 7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000, FRAME);
    start(16'h0000, 0, 0);
    chk_frame("zero_nolz", 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, FRAME);

    // load lands mid-slot of digit 1: digit 1 keeps the old pattern, digit 2 shows new
    start(16'h1234, 0, 0);
    for (int k = 0; k < FRAME; k++) begin
      logic [6:0] segs [4];
      int slot, w;
      segs = '{7'b0110011, 7'b1111001, 7'b1011111, 7'b1011011};
      if (k > 0) step();
      if (k == 6) begin value = 16'h5678; load = 1'b1; end
      if (k == 7) load = 1'b0;
      @(negedge clk);
      slot = k / SLOT;
      w    = k % SLOT;
      if (w < PRESCALE) lit("midslot_load", segs[slot], 4'(1 << slot));
      else              lit("midslot_load", 7'b0, 4'b0);
    end

    // enable dropped during a gap
    start(16'h1234, 0, 0);
    chk_frame("pre_gap", 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, PRESCALE);
    step();
    enable = 1'b0;
    @(negedge clk);
    lit("gap_dark", 7'b0, 4'b0);
    step();
    @(negedge clk);
    lit("disabled", 7'b0, 4'b0);
    enable = 1'b1;
    step();
    chk_frame("restart", 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, SLOT + 1);

    // asynchronous reset pulse between edges mid-SHOW
    start(16'h1234, 0, 0);
    chk_frame("pre_rst", 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 2);
    step();
    rst = 1'b1;
    #1 lit("async_rst", 7'b0, 4'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    lit("after_rst", 7'b0, 4'b0);
    step();
    @(negedge clk);
    lit("rst_cleared", 7'b1111110, 4'b0001);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] v;
      step();
      v = 16'($urandom);
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 1) == 1) v[4*i +: 4] = 4'h0;
      rst         = ($urandom_range(0, 199) == 0);
      enable      = ($urandom_range(0, 99) < 96);
      load        = ($urandom_range(0, 9) == 0);
      value       = v;
      hex_mode    = 1'($urandom_range(0, 1));
      lz_suppress = 1'($urandom_range(0, 1));
    end
    step();
    rst = 1'b0; load = 1'b0; enable = 1'b0;
    step();
    step();
    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
